// File: rtl/advanced_wrapping_counter.sv
// Up/down modulo-RANGE counter with optional lap bit, synchronous load,
// combinational min/max flags and registered one-cycle wrap pulses.
module advanced_wrapping_counter #(
  parameter  int unsigned RANGE        = 4,
  parameter  int unsigned RESET_VALUE  = 0,
  parameter  int unsigned LAP_BIT      = 1,
  localparam int unsigned WIDTH_NO_LAP = $clog2(RANGE),
  localparam int unsigned WIDTH        = WIDTH_NO_LAP + LAP_BIT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_enable,
  input  logic [WIDTH-1:0] load_count,
  input  logic             decrement,
  input  logic             increment,
  output logic [WIDTH-1:0] count,
  output logic             minimum,
  output logic             maximum,
  output logic             underflow,
  output logic             overflow
);

  localparam logic [WIDTH_NO_LAP-1:0] COUNT_MIN = '0;
  localparam logic [WIDTH_NO_LAP-1:0] COUNT_MAX = WIDTH_NO_LAP'(RANGE - 1);
  localparam logic [WIDTH_NO_LAP-1:0] INDEX_RST = WIDTH_NO_LAP'(RESET_VALUE);

  logic [WIDTH_NO_LAP-1:0] index;
  logic [WIDTH_NO_LAP-1:0] load_index;
  logic                    step_up;
  logic                    step_down;
  logic                    at_min;
  logic                    at_max;
  logic                    wrap_up;
  logic                    wrap_down;

  always_comb begin
    step_up   = increment & ~decrement;
    step_down = decrement & ~increment;
    at_min    = (index == COUNT_MIN);
    at_max    = (index == COUNT_MAX);
    wrap_up   = step_up & at_max;
    wrap_down = step_down & at_min;
    // Out-of-range load values saturate so the index never leaves 0..RANGE-1.
    load_index = load_count[WIDTH_NO_LAP-1:0];
    if (load_index > COUNT_MAX) begin
      load_index = COUNT_MAX;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      index     <= INDEX_RST;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (load_enable) begin
      index     <= load_index;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wrap_up;
      underflow <= wrap_down;
      if (step_up) begin
        index <= at_max ? COUNT_MIN : index + WIDTH_NO_LAP'(1);
      end else if (step_down) begin
        index <= at_min ? COUNT_MAX : index - WIDTH_NO_LAP'(1);
      end
    end
  end

  assign minimum = at_min;
  assign maximum = at_max;

  if (LAP_BIT != 0) begin : g_lap
    logic lap;

    always_ff @(posedge clock) begin
      if (reset) begin
        lap <= 1'b0;
      end else if (load_enable) begin
        lap <= load_count[WIDTH-1];
      end else if (wrap_up | wrap_down) begin
        lap <= ~lap;
      end
    end

    assign count = {lap, index};
  end else begin : g_no_lap
    assign count = index;
  end

endmodule

// File: tb/tb_advanced_wrapping_counter.sv
// Scoreboard bench: a RANGE=4 counter with lap bit and a RANGE=5 counter
// without lap bit (RESET_VALUE=2) driven in lockstep against an arithmetic model.
module tb_advanced_wrapping_counter;

  localparam int RA  = 4;
  localparam int RB  = 5;
  localparam int RVB = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_enable = 1'b0;
  logic       increment = 1'b0;
  logic       decrement = 1'b0;
  logic [2:0] load_a = '0;
  logic [2:0] load_b = '0;
  logic [2:0] count_a, count_b;
  logic       min_a, max_a, ovf_a, unf_a;
  logic       min_b, max_b, ovf_b, unf_b;

  typedef struct {
    logic [2:0] ca;
    logic       mina, maxa, ovfa, unfa;
    logic [2:0] cb;
    logic       minb, maxb, ovfb, unfb;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // model state
  int ia = 0, lap_a = 0, ib = RVB;

  advanced_wrapping_counter #(.RANGE(RA), .RESET_VALUE(0), .LAP_BIT(1)) dut_a (
    .clock(clock), .reset(reset), .load_enable(load_enable), .load_count(load_a),
    .decrement(decrement), .increment(increment), .count(count_a),
    .minimum(min_a), .maximum(max_a), .underflow(unf_a), .overflow(ovf_a)
  );

  advanced_wrapping_counter #(.RANGE(RB), .RESET_VALUE(RVB), .LAP_BIT(0)) dut_b (
    .clock(clock), .reset(reset), .load_enable(load_enable), .load_count(load_b),
    .decrement(decrement), .increment(increment), .count(count_b),
    .minimum(min_b), .maximum(max_b), .underflow(unf_b), .overflow(ovf_b)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: each cycle the DUTs present one result; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("count_a",     8'(count_a), 8'(e.ca));
        chk("minimum_a",   8'(min_a),   8'(e.mina));
        chk("maximum_a",   8'(max_a),   8'(e.maxa));
        chk("overflow_a",  8'(ovf_a),   8'(e.ovfa));
        chk("underflow_a", 8'(unf_a),   8'(e.unfa));
        chk("count_b",     8'(count_b), 8'(e.cb));
        chk("minimum_b",   8'(min_b),   8'(e.minb));
        chk("maximum_b",   8'(max_b),   8'(e.maxb));
        chk("overflow_b",  8'(ovf_b),   8'(e.ovfb));
        chk("underflow_b", 8'(unf_b),   8'(e.unfb));
      end
    end
  end

  task automatic cycle(input bit r, input bit le, input bit inc, input bit dec,
                       input logic [2:0] la_in, input logic [2:0] lb_in);
    exp_t e;
    int   lb_idx;
    @(negedge clock);
    reset       = r;
    load_enable = le;
    increment   = inc;
    decrement   = dec;
    load_a      = la_in;
    load_b      = lb_in;
    e.ovfa = 1'b0; e.unfa = 1'b0; e.ovfb = 1'b0; e.unfb = 1'b0;
    if (r) begin
      ia = 0; lap_a = 0; ib = RVB;
    end else if (le) begin
      ia     = int'(la_in[1:0]);
      lap_a  = int'(la_in[2]);
      lb_idx = int'(lb_in);
      ib     = (lb_idx > RB - 1) ? RB - 1 : lb_idx;
    end else if (inc && !dec) begin
      if (ia == RA - 1) begin e.ovfa = 1'b1; lap_a = 1 - lap_a; end
      if (ib == RB - 1) e.ovfb = 1'b1;
      ia = (ia + 1) % RA;
      ib = (ib + 1) % RB;
    end else if (dec && !inc) begin
      if (ia == 0) begin e.unfa = 1'b1; lap_a = 1 - lap_a; end
      if (ib == 0) e.unfb = 1'b1;
      ia = (ia + RA - 1) % RA;
      ib = (ib + RB - 1) % RB;
    end
    e.ca   = 3'(lap_a * RA + ia);
    e.mina = (ia == 0);
    e.maxa = (ia == RA - 1);
    e.cb   = 3'(ib);
    e.minb = (ib == 0);
    e.maxb = (ib == RB - 1);
    @(posedge clock);
    exp_q.push_back(e);
  endtask

  initial begin
    int waited;
    cycle(1, 0, 0, 0, 3'd0, 3'd0);                           // reset
    repeat (4) cycle(0, 0, 1, 0, 3'd0, 3'd0);                // 1,2,3 then wrap to 0
    repeat (4) cycle(0, 0, 0, 1, 3'd0, 3'd0);                // wrap to 3, then 2,1,0
    repeat (4) cycle(0, 0, 1, 0, 3'd0, 3'd0);                // full up cycle
    repeat (4) cycle(0, 0, 0, 1, 3'd0, 3'd0);                // full down cycle
    cycle(0, 0, 1, 1, 3'd0, 3'd0);                           // both set: hold
    cycle(0, 1, 1, 0, 3'd3, 3'd5);                           // load 3 / load 5 clamps to 4
    cycle(0, 0, 0, 0, 3'd0, 3'd0);
    cycle(0, 1, 0, 1, 3'd6, 3'd7);                           // load with lap set / clamp from 7
    cycle(0, 0, 1, 0, 3'd0, 3'd0);
    repeat (2) cycle(0, 0, 1, 0, 3'd0, 3'd0);
    cycle(1, 0, 1, 0, 3'd0, 3'd0);                           // reset mid-count
    cycle(0, 0, 1, 0, 3'd0, 3'd0);
    for (int i = 0; i < 1000; i++) begin
      cycle($urandom_range(63) == 0, $urandom_range(15) == 0,
            1'($urandom_range(1)), 1'($urandom_range(1)),
            3'($urandom_range(7)), 3'($urandom_range(7)));
    end
    cycle(0, 0, 0, 0, 3'd0, 3'd0);
    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(negedge clock);
      #1;
      waited++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d results left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/advanced_wrapping_counter.md
Name: advanced_wrapping_counter

Overview:
- Up/down modulo-RANGE counter, wrapping in both directions.
- Optional lap bit toggles on every wrap; intended for FIFO/ring-buffer pointers where full and empty are told apart by lap parity.
- Provides a synchronous load, combinational min/max flags, and registered one-cycle overflow/underflow pulses.

Parameters:
- RANGE, 4, number of index states (0..RANGE-1); must be ≥2; need not be a power of two.
- RESET_VALUE, 0, index value after reset; must be in 0..RANGE-1.
- LAP_BIT, 1, 1 appends a lap bit as count MSB; 0 omits it.
- Derived: WIDTH_NO_LAP = clog2(RANGE); WIDTH = WIDTH_NO_LAP + LAP_BIT; COUNT_MIN = 0; COUNT_MAX = RANGE-1.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_enable  in  1  load load_count on the next edge.
- load_count  in  WIDTH  value to load (index in low bits, lap in MSB when LAP_BIT=1).
- decrement  in  1  step down one.
- increment  in  1  step up one.
- count  out  WIDTH  registered counter value: index in [WIDTH_NO_LAP-1:0], lap in [WIDTH-1] when LAP_BIT=1.
- minimum  out  1  combinational: index == COUNT_MIN.
- maximum  out  1  combinational: index == COUNT_MAX.
- underflow  out  1  registered one-cycle pulse: a down-wrap occurred on the last edge.
- overflow  out  1  registered one-cycle pulse: an up-wrap occurred on the last edge.

Behaviour:
- One clock domain. Reset is synchronous, active-high, and has the highest priority.
- On reset: index = RESET_VALUE, lap = 0, overflow = 0, underflow = 0.
- minimum and maximum follow the index combinationally, including during and after reset.
- Per rising edge, priority order: reset > load > step.
- Load (load_enable=1):
  - count <= load_count; increment and decrement are ignored; overflow = underflow = 0 on the next cycle.
  - A loaded index > COUNT_MAX is clamped to COUNT_MAX; the lap bit is loaded unchanged.
- increment=1, decrement=0:
  - index < COUNT_MAX: index+1, lap unchanged, overflow <= 0.
  - index == COUNT_MAX: index <= 0, lap toggles, overflow <= 1.
- decrement=1, increment=0:
  - index > 0: index-1, lap unchanged, underflow <= 0.
  - index == 0: index <= COUNT_MAX, lap toggles, underflow <= 1.
- Both set or both clear: count holds; overflow = underflow = 0.
- overflow and underflow:
  - Never both high; each is high for exactly the one cycle after the wrapping edge.
  - Continuous stepping produces a pulse once every RANGE cycles.
- Non-power-of-two RANGE: index never takes values ≥ RANGE; wrap is at RANGE-1, not at 2^WIDTH_NO_LAP-1.
- LAP_BIT=0: count is WIDTH_NO_LAP bits; wrap behaviour is otherwise identical.
- Latency: count and the pulses update one edge after inputs are sampled.

Test Plan:
- Reset (RANGE=4, RESET_VALUE=0, LAP_BIT=1): pulse reset for one edge -> count index 0, minimum=1, maximum=0, overflow=underflow=0.
- Increment from 0 to 3 -> index 1, 2, 3 on successive edges, no pulses, lap unchanged, maximum=1 at 3. One more increment -> index 0, lap toggled, overflow=1 for one cycle, minimum=1.
- Decrement at index 0 -> index 3, lap toggled, underflow=1 for one cycle, maximum=1. Continue decrementing -> 2, 1, 0 with no pulses.
- Full cycles: 4 increments from 0 -> single overflow on the 3->0 step, back at 0. 4 decrements from 0 -> single underflow on the 0->3 step, back at 0, lap toggled.
- Random (1000 cycles): increment and decrement each random with p=0.5 -> count matches a wrap model (both set = hold); pulses and lap toggles only on single-direction wraps; minimum and maximum match the index.
- Load: load_enable=1, load_count=3 with increment=1 -> index 3, maximum=1, minimum=0, no pulses. Also: load 5 with RANGE=5 -> clamped to 4; reset asserted mid-count -> RESET_VALUE on the next edge.
